// File: rtl/mem_scheduler_pkg.sv
// Shared types and constants for the memory scheduler.
// Holds FSM state codes, owner codes, IO base and the fetch width code.
package mem_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_IF = 2'd0,
        OWN_DM = 2'd1,
        OWN_PF = 2'd2
    } owner_t;

    localparam logic [31:0] IO_BASE    = 32'h0003_0000;
    localparam logic [2:0]  WIDTH_WORD = 3'b100;
    localparam logic [1:0]  STARVE_MAX = 2'd2;

endpackage

// File: rtl/mem_scheduler_pf_buffer.sv
// pf_buffer: single-entry prefetch buffer with hit compare and invalidate.
// Ports: clk/rst/rdy, lookup addr -> o_hit/o_data, issue/done of a prefetch,
//        flush and store-invalidate (word address) inputs.
module pf_buffer
    import mem_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] i_lookup_addr,
    input  logic        i_flush,
    input  logic        i_issue,
    input  logic [31:0] i_issue_addr,
    input  logic        i_done,
    input  logic [31:0] i_done_data,
    input  logic        i_st_inv,
    input  logic [29:0] i_st_word,
    output logic        o_hit,
    output logic [31:0] o_data
);

    logic        r_valid;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [31:0] r_fl_addr;
    logic        r_killed;

    assign o_hit  = r_valid && (i_lookup_addr == r_addr);
    assign o_data = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_addr    <= 32'd0;
            r_data    <= 32'd0;
            r_fl_addr <= 32'd0;
            r_killed  <= 1'b0;
        end else if (rdy) begin
            if (i_issue) begin
                r_fl_addr <= i_issue_addr;
                r_killed  <= 1'b0;
            end
            // A killed prefetch still runs to completion but is discarded.
            if (i_done && !r_killed && !i_flush) begin
                r_valid <= 1'b1;
                r_addr  <= r_fl_addr;
                r_data  <= i_done_data;
            end
            if (i_flush) begin
                r_valid  <= 1'b0;
                r_killed <= 1'b1;
            end
            if (i_st_inv) begin
                if (i_st_word == r_addr[31:2]) begin
                    r_valid <= 1'b0;
                end
                if (i_st_word == r_fl_addr[31:2]) begin
                    r_killed <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_scheduler.sv
// mem_scheduler: arbitrates fetch, data and prefetch onto one byte-serial accesser.
// Ports: clk/rst/rdy, if_* fetch port, dm_* data port, acc_* accesser port.
module mem_scheduler
    import mem_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_ack,
    output logic [31:0] if_data,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [2:0]  dm_width,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        acc_re,
    output logic        acc_we,
    output logic [2:0]  acc_width,
    output logic [31:0] acc_addr,
    output logic [31:0] acc_wdata,
    input  logic        acc_busy,
    input  logic [31:0] acc_rdata
);

    state_t      r_state;
    state_t      w_next;
    owner_t      r_owner;
    logic        r_dm_st;
    logic        r_acc_re;
    logic        r_acc_we;
    logic [2:0]  r_acc_width;
    logic [31:0] r_acc_addr;
    logic [31:0] r_acc_wdata;
    logic        r_if_ack;
    logic        r_dm_ack;
    logic [31:0] r_if_data;
    logic [31:0] r_dm_rdata;
    logic [1:0]  r_starve;
    logic        r_pf_tgt_v;
    logic [31:0] r_pf_tgt;

    logic        w_hold;
    logic        w_arb;
    logic        w_hit_raw;
    logic        w_hit;
    logic        w_if_hit;
    logic        w_if_miss;
    logic        w_force_if;
    logic        w_gnt_dm;
    logic        w_gnt_if;
    logic        w_gnt_pf;
    logic        w_done;
    logic        w_if_done;
    logic        w_pf_done;
    logic        w_st_inv;
    logic        w_if_cpl;
    logic        w_pf_ok;
    logic [31:0] w_cpl_addr;
    logic [31:0] w_pf_data;

    // Requesters still hold req during their ack cycle; skip
    // arbitration then so a finished request is never re-granted.
    assign w_hold     = r_if_ack | r_dm_ack;
    assign w_arb      = (r_state == ST_IDLE) & ~w_hold;
    assign w_hit      = w_hit_raw & ~if_flush;
    assign w_if_hit   = w_arb & if_req & w_hit;
    assign w_if_miss  = if_req & ~w_hit;
    assign w_force_if = (r_starve == STARVE_MAX) & w_if_miss;
    assign w_gnt_dm   = w_arb & dm_req & ~w_force_if;
    assign w_gnt_if   = w_arb & w_if_miss & (~dm_req | w_force_if);
    assign w_gnt_pf   = w_arb & ~dm_req & ~if_req & r_pf_tgt_v & ~if_flush;
    assign w_done     = (r_state == ST_WAIT) & ~acc_busy;
    assign w_if_done  = w_done & (r_owner == OWN_IF);
    assign w_pf_done  = w_done & (r_owner == OWN_PF);
    assign w_st_inv   = w_gnt_dm & dm_we;
    assign w_if_cpl   = w_if_done | w_if_hit;
    assign w_cpl_addr = w_if_done ? r_acc_addr : if_addr;
    // A < IO_BASE-4 is A+4 < IO_BASE without wrap-around at the top.
    assign w_pf_ok    = w_cpl_addr < (IO_BASE - 32'd4);

    pf_buffer u_pf (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .i_lookup_addr(if_addr),
        .i_flush      (if_flush),
        .i_issue      (w_gnt_pf),
        .i_issue_addr (r_pf_tgt),
        .i_done       (w_pf_done),
        .i_done_data  (acc_rdata),
        .i_st_inv     (w_st_inv),
        .i_st_word    (dm_addr[31:2]),
        .o_hit        (w_hit_raw),
        .o_data       (w_pf_data)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_gnt_dm | w_gnt_if | w_gnt_pf) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT: begin
                if (!acc_busy) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (rdy) begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= OWN_IF;
            r_dm_st     <= 1'b0;
            r_acc_re    <= 1'b0;
            r_acc_we    <= 1'b0;
            r_acc_width <= 3'b000;
            r_acc_addr  <= 32'd0;
            r_acc_wdata <= 32'd0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_if_data   <= 32'd0;
            r_dm_rdata  <= 32'd0;
            r_starve    <= 2'd0;
            r_pf_tgt_v  <= 1'b0;
            r_pf_tgt    <= 32'd0;
        end else if (rdy) begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;

            if (r_state == ST_ISSUE) begin
                r_acc_re <= 1'b0;
                r_acc_we <= 1'b0;
            end

            unique case (1'b1)
                w_gnt_dm: begin
                    r_owner     <= OWN_DM;
                    r_dm_st     <= dm_we;
                    r_acc_re    <= ~dm_we;
                    r_acc_we    <= dm_we;
                    r_acc_width <= dm_width;
                    r_acc_addr  <= dm_addr;
                    r_acc_wdata <= dm_wdata;
                end
                w_gnt_if: begin
                    r_owner     <= OWN_IF;
                    r_acc_re    <= 1'b1;
                    r_acc_we    <= 1'b0;
                    r_acc_width <= WIDTH_WORD;
                    r_acc_addr  <= if_addr;
                end
                w_gnt_pf: begin
                    r_owner     <= OWN_PF;
                    r_acc_re    <= 1'b1;
                    r_acc_we    <= 1'b0;
                    r_acc_width <= WIDTH_WORD;
                    r_acc_addr  <= r_pf_tgt;
                end
                default: ;
            endcase

            // Buffer hit is served alongside any DM grant this cycle.
            if (w_if_hit) begin
                r_if_ack  <= 1'b1;
                r_if_data <= w_pf_data;
            end

            if (w_done) begin
                unique case (r_owner)
                    OWN_IF: begin
                        r_if_ack  <= 1'b1;
                        r_if_data <= acc_rdata;
                    end
                    OWN_DM: begin
                        r_dm_ack <= 1'b1;
                        if (!r_dm_st) begin
                            r_dm_rdata <= acc_rdata;
                        end
                    end
                    default: ;
                endcase
            end

            if (w_gnt_if | w_if_hit) begin
                r_starve <= 2'd0;
            end else if (w_gnt_dm) begin
                if (!w_if_miss) begin
                    r_starve <= 2'd0;
                end else if (r_starve != STARVE_MAX) begin
                    r_starve <= r_starve + 2'd1;
                end
            end

            if (if_flush) begin
                r_pf_tgt_v <= 1'b0;
            end else if (w_if_cpl) begin
                r_pf_tgt_v <= w_pf_ok;
                r_pf_tgt   <= w_cpl_addr + 32'd4;
            end else if (w_gnt_pf) begin
                r_pf_tgt_v <= 1'b0;
            end
        end
    end

    assign if_ack    = r_if_ack;
    assign if_data   = r_if_data;
    assign dm_ack    = r_dm_ack;
    assign dm_rdata  = r_dm_rdata;
    assign acc_re    = r_acc_re;
    assign acc_we    = r_acc_we;
    assign acc_width = r_acc_width;
    assign acc_addr  = r_acc_addr;
    assign acc_wdata = r_acc_wdata;

endmodule

// File: tb/tb_mem_scheduler.sv
// Directed bench for mem_scheduler with a byte-serial accesser model.
// Registered busy; read data appears when busy falls.
module tb_mem_scheduler;
    import mem_scheduler_pkg::*;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_ack;
    logic [31:0] if_data;
    logic        dm_req;
    logic        dm_we;
    logic [2:0]  dm_width;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        acc_re;
    logic        acc_we;
    logic [2:0]  acc_width;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_busy;
    logic [31:0] acc_rdata;

    int total = 0;
    int bad   = 0;

    mem_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_ack   (if_ack),
        .if_data  (if_data),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_width (dm_width),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .acc_re   (acc_re),
        .acc_we   (acc_we),
        .acc_width(acc_width),
        .acc_addr (acc_addr),
        .acc_wdata(acc_wdata),
        .acc_busy (acc_busy),
        .acc_rdata(acc_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    function automatic int nbytes(input logic [2:0] w);
        case (w)
            3'b001:  return 1;
            3'b010:  return 2;
            default: return 4;
        endcase
    endfunction

    // Accesser model: one byte per cycle, busy registered.
    int          m_rem;
    logic [31:0] m_addr;
    int          starts = 0;
    logic [31:0] log_q[$];

    always @(posedge clk) begin
        if (rst) begin
            acc_busy  <= 1'b0;
            acc_rdata <= 32'd0;
            m_rem     <= 0;
        end else if (rdy) begin
            if (acc_re || acc_we) begin
                starts <= starts + 1;
                log_q.push_back(acc_addr);
                m_addr <= acc_addr;
                if (nbytes(acc_width) == 1) begin
                    acc_busy  <= 1'b0;
                    acc_rdata <= mem(acc_addr);
                end else begin
                    acc_busy <= 1'b1;
                    m_rem    <= nbytes(acc_width) - 1;
                end
            end else if (acc_busy) begin
                if (m_rem == 1) begin
                    acc_busy  <= 1'b0;
                    acc_rdata <= mem(m_addr);
                end else begin
                    m_rem <= m_rem - 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_if_ack(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!if_ack && n < 200);
        chk(tag, 32'(if_ack), 32'd1);
    endtask

    task automatic settle(input string tag);
        int n = 0;
        logic ok = 1'b0;
        while (!ok && n < 200) begin
            step();
            n++;
            ok = (dut.r_state == ST_IDLE) && !dut.r_pf_tgt_v
                 && !if_ack && !dm_ack;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s0;
        int base;
        int dmn;
        int acks;

        rst = 1'b1; rdy = 1'b1;
        if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_width = 3'b000;
        dm_addr = 32'd0; dm_wdata = 32'd0;
        step();
        step();
        chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        chk("rst_acc_re", 32'(acc_re), 32'd0);
        chk("rst_acc_we", 32'(acc_we), 32'd0);
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_dm_ack", 32'(dm_ack), 32'd0);
        chk("rst_acc_addr", acc_addr, 32'd0);
        chk("rst_acc_width", 32'(acc_width), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_pf_valid", 32'(dut.u_pf.r_valid), 32'd0);
        rst = 1'b0;

        // Fetch 0x100, then prefetch 0x104 and hit on it.
        if_req = 1'b1; if_addr = 32'h100;
        wait_if_ack("if100_ack");
        chk("if100_data", if_data, mem(32'h100));
        if_req = 1'b0;
        n = 0;
        while (!dut.u_pf.r_valid && n < 100) begin
            step();
            n++;
        end
        chk("pf104_valid", 32'(dut.u_pf.r_valid), 32'd1);
        chk("pf104_addr", dut.u_pf.r_addr, 32'h104);
        chk("pf104_issued", log_q[log_q.size()-1], 32'h104);
        s0 = starts;
        if_req = 1'b1; if_addr = 32'h104;
        step();
        chk("hit104_ack", 32'(if_ack), 32'd1);
        chk("hit104_data", if_data, mem(32'h104));
        chk("hit104_noacc", 32'(starts), 32'(s0));
        if_req = 1'b0;
        settle("settle1");

        // DM and IF contend: starvation guard lets IF in third.
        base = log_q.size();
        dm_req = 1'b1; dm_we = 1'b0; dm_width = 3'b100; dm_addr = 32'h1000;
        if_req = 1'b1; if_addr = 32'h400;
        dmn = 0;
        n = 0;
        while ((dmn < 4 || if_req) && n < 400) begin
            step();
            n++;
            if (dm_ack) begin
                dmn++;
                if (dmn < 4) dm_addr = 32'h1000 + 32'(4 * dmn);
                else dm_req = 1'b0;
            end
            if (if_ack) if_req = 1'b0;
        end
        chk("arb_dm_count", 32'(dmn), 32'd4);
        chk("arb_g0", log_q[base], 32'h1000);
        chk("arb_g1", log_q[base+1], 32'h1004);
        chk("arb_g2", log_q[base+2], 32'h400);
        chk("arb_g3", log_q[base+3], 32'h1008);
        chk("arb_g4", log_q[base+4], 32'h100C);
        chk("arb_dm_rdata", dm_rdata, mem(32'h100C));
        chk("arb_if_data", if_data, mem(32'h400));
        settle("settle2");

        // Refill buffer with 0x104, then a byte store to 0x106 kills it.
        if_req = 1'b1; if_addr = 32'h100;
        wait_if_ack("if100b_ack");
        if_req = 1'b0;
        settle("settle3");
        chk("pf104b_valid", 32'(dut.u_pf.r_valid), 32'd1);
        chk("pf104b_addr", dut.u_pf.r_addr, 32'h104);
        dm_req = 1'b1; dm_we = 1'b1; dm_width = 3'b001;
        dm_addr = 32'h106; dm_wdata = 32'hAB;
        step();
        chk("st_we", 32'(acc_we), 32'd1);
        chk("st_re", 32'(acc_re), 32'd0);
        chk("st_width", 32'(acc_width), 32'h1);
        chk("st_addr", acc_addr, 32'h106);
        chk("st_wdata", acc_wdata, 32'hAB);
        chk("st_pf_inval", 32'(dut.u_pf.r_valid), 32'd0);
        step();
        chk("st_we_1cyc", 32'(acc_we), 32'd0);
        chk("st_ack_early", 32'(dm_ack), 32'd0);
        step();
        chk("st_ack", 32'(dm_ack), 32'd1);
        dm_req = 1'b0; dm_we = 1'b0;
        s0 = log_q.size();
        if_req = 1'b1; if_addr = 32'h104;
        wait_if_ack("if104m_ack");
        chk("if104m_acc", 32'(log_q.size()), 32'(s0 + 1));
        chk("if104m_addr", log_q[log_q.size()-1], 32'h104);
        chk("if104m_data", if_data, mem(32'h104));
        if_req = 1'b0;
        settle("settle4");

        // Flush while the prefetch of 0x204 is in flight.
        if_req = 1'b1; if_addr = 32'h200;
        wait_if_ack("if200_ack");
        if_req = 1'b0;
        n = 0;
        while (!(dut.r_state == ST_ISSUE && acc_re) && n < 100) begin
            step();
            n++;
        end
        chk("pf204_strobe", acc_addr, 32'h204);
        if_flush = 1'b1;
        step();
        if_flush = 1'b0;
        acks = 0;
        n = 0;
        while (dut.r_state != ST_IDLE && n < 100) begin
            step();
            n++;
            if (if_ack) acks++;
        end
        step();
        if (if_ack) acks++;
        chk("flush_idle", 32'(dut.r_state), 32'(ST_IDLE));
        chk("flush_noack", 32'(acks), 32'd0);
        chk("flush_pf_valid", 32'(dut.u_pf.r_valid), 32'd0);
        chk("flush_tgt", 32'(dut.r_pf_tgt_v), 32'd0);

        // Fetch just below the IO region: no prefetch follows.
        if_req = 1'b1; if_addr = 32'h0002_FFFC;
        wait_if_ack("io_ack");
        if_req = 1'b0;
        s0 = log_q.size();
        for (int i = 0; i < 6; i++) step();
        chk("io_no_pf", 32'(log_q.size()), 32'(s0));
        chk("io_tgt", 32'(dut.r_pf_tgt_v), 32'd0);

        // Reset in WAIT abandons the fetch.
        if_req = 1'b1; if_addr = 32'h500;
        n = 0;
        while (dut.r_state != ST_WAIT && n < 50) begin
            step();
            n++;
        end
        chk("rw_in_wait", 32'(dut.r_state), 32'(ST_WAIT));
        rst = 1'b1;
        step();
        rst = 1'b0;
        if_req = 1'b0;
        chk("rw_state", 32'(dut.r_state), 32'(ST_IDLE));
        chk("rw_re", 32'(acc_re), 32'd0);
        chk("rw_we", 32'(acc_we), 32'd0);
        chk("rw_if_ack", 32'(if_ack), 32'd0);
        chk("rw_dm_ack", 32'(dm_ack), 32'd0);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (if_ack) acks++;
        end
        chk("rw_noack", 32'(acks), 32'd0);

        // rdy low for 3 cycles in ISSUE, then across an ack.
        if_req = 1'b1; if_addr = 32'h600;
        step();
        chk("rdy_issue", 32'(dut.r_state), 32'(ST_ISSUE));
        chk("rdy_re0", 32'(acc_re), 32'd1);
        s0 = starts;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rdy_re_hold", 32'(acc_re), 32'd1);
        end
        rdy = 1'b1;
        step();
        chk("rdy_re_drop", 32'(acc_re), 32'd0);
        chk("rdy_wait", 32'(dut.r_state), 32'(ST_WAIT));
        chk("rdy_one_start", 32'(starts), 32'(s0 + 1));
        wait_if_ack("rdy_ack");
        chk("rdy_data", if_data, mem(32'h600));
        if_req = 1'b0;
        rdy = 1'b0;
        step();
        step();
        chk("rdy_ack_hold", 32'(if_ack), 32'd1);
        rdy = 1'b1;
        step();
        chk("rdy_ack_drop", 32'(if_ack), 32'd0);
        settle("settle5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
